branch_resolve: RTL and testbench

- Resolution end of the branch prediction interface. It holds the fetch-time prediction for every in-flight conditional branch and JAL, in program order.
- It compares each prediction with the execute-stage outcome. On a mismatch it issues a one-cycle redirect/flush. It also generates the training strobe (branch/result) consumed by the predictor.
- Sits between fetch (push side) and execute (resolve side) in riscv_core.

---
 rtl/branch_resolve_pkg.sv | 24 ++
 rtl/branch_resolve_if.sv | 36 +++
 rtl/branch_resolve_pred_fifo.sv | 56 +++++
 rtl/branch_resolve.sv | 102 ++++++++++
 tb/tb_branch_resolve.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_resolve_pkg.sv
// branch_resolve_pkg
//   Shared definitions for the branch resolution slice: control-flow opcodes,
//   the layout of one in-flight prediction entry and the default queue depth.
package branch_resolve_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam int DEFAULT_DEPTH = 4;

    // One fetch-time prediction, held until execute resolves it.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
        logic        is_branch;
    } pred_entry_t;

    // Sequential successor of a control instruction; wraps at 2^32.
    function automatic logic [31:0] fallthrough_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// branch_resolve_if
//   Fetch push channel, execute resolve channel and the redirect / training
//   outputs of branch_resolve.
//   master: fetch/execute side (drives push_* and resolve_*)
//   slave : branch_resolve (drives push_ready, redirect*, flush, upd_*)
interface branch_resolve_if;

    logic        push_valid;
    logic        push_ready;
    logic [31:0] push_pc;
    logic [31:0] push_target;
    logic        push_taken;
    logic        push_is_branch;

    logic        resolve_valid;
    logic        resolve_taken;

    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        upd_branch;
    logic        upd_result;

    modport master (
        output push_valid, push_pc, push_target, push_taken, push_is_branch,
        output resolve_valid, resolve_taken,
        input  push_ready, redirect, redirect_pc, flush, upd_branch, upd_result
    );

    modport slave (
        input  push_valid, push_pc, push_target, push_taken, push_is_branch,
        input  resolve_valid, resolve_taken,
        output push_ready, redirect, redirect_pc, flush, upd_branch, upd_result
    );

endinterface

// File: rtl/branch_resolve_pred_fifo.sv
// branch_resolve_pred_fifo
//   Synchronous FIFO of prediction entries in program order.
//   clk, rst      : clock, async active-high reset
//   push / wdata  : write an entry (ignored when full)
//   pop  / rdata  : rdata is the oldest entry; pop removes it (ignored when empty)
//   clear         : discard every entry; wins over push and pop
//   count         : occupancy, 0..DEPTH
module branch_resolve_pred_fifo
    import branch_resolve_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  pred_entry_t   wdata,
    output pred_entry_t   rdata,
    output logic [CW-1:0] count
);

    pred_entry_t     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push_ok;
    logic            pop_ok;

    assign push_ok = push && (count != CW'(DEPTH));
    assign pop_ok  = pop  && (count != '0);
    assign rdata   = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clear) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/branch_resolve.sv
// branch_resolve
//   Holds fetch-time predictions for in-flight branches/JALs, checks each one
//   against the execute outcome, and produces a one-cycle redirect/flush on a
//   mispredict plus the predictor training strobe.
//   clk, rst          : clock, async active-high reset
//   br (slave)        : push channel, resolve channel, redirect and training
//   count             : entries in flight
//   err_underflow     : sticky, a resolve arrived with nothing in flight
//   branch_count      : resolved conditional branches (wraps)
//   mispredict_count  : resolved mispredictions, branch and JAL (wraps)
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    parameter  int CNT_W = 32,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    branch_resolve_if.slave  br,
    output logic [CW-1:0]    count,
    output logic             err_underflow,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    pred_entry_t head;
    pred_entry_t wentry;
    logic        push_fire;
    logic        pop_fire;
    logic        actual;
    logic        mispredict;

    logic        redirect_q;
    logic [31:0] redirect_pc_q;
    logic        upd_branch_q;
    logic        upd_result_q;

    // Ready looks only at the occupancy at cycle start: a pop in the same
    // cycle does not make room.
    assign br.push_ready = (count < CW'(DEPTH));
    assign push_fire     = br.push_valid && br.push_ready;
    assign pop_fire      = br.resolve_valid && (count != '0);

    // JALs are always taken, whatever execute reports.
    assign actual     = head.is_branch ? br.resolve_taken : 1'b1;
    assign mispredict = pop_fire && (actual != head.taken);

    always_comb begin
        wentry           = '0;
        wentry.pc        = br.push_pc;
        wentry.target    = br.push_target;
        wentry.taken     = br.push_taken;
        wentry.is_branch = br.push_is_branch;
    end

    // A mispredict discards every younger entry, and a same-cycle push is
    // wrong-path, so clear wins over both.
    branch_resolve_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_fire),
        .pop   (pop_fire),
        .clear (mispredict),
        .wdata (wentry),
        .rdata (head),
        .count (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_q       <= 1'b0;
            redirect_pc_q    <= '0;
            upd_branch_q     <= 1'b0;
            upd_result_q     <= 1'b0;
            err_underflow    <= 1'b0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            redirect_q   <= mispredict;
            upd_branch_q <= pop_fire && head.is_branch;
            upd_result_q <= pop_fire && actual;
            if (mispredict) begin
                redirect_pc_q    <= actual ? head.target : fallthrough_pc(head.pc);
                mispredict_count <= mispredict_count + CNT_W'(1);
            end
            if (pop_fire && head.is_branch) begin
                branch_count <= branch_count + CNT_W'(1);
            end
            if (br.resolve_valid && (count == '0)) begin
                err_underflow <= 1'b1;
            end
        end
    end

    assign br.redirect    = redirect_q;
    assign br.flush       = redirect_q;
    assign br.redirect_pc = redirect_pc_q;
    assign br.upd_branch  = upd_branch_q;
    assign br.upd_result  = upd_result_q;

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;
    import branch_resolve_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [CW-1:0]    count;
    logic             err_underflow;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;

    always #5 clk = ~clk;

    branch_resolve_if bus ();

    branch_resolve #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .br               (bus),
        .count            (count),
        .err_underflow    (err_underflow),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    typedef struct {
        logic        upd_branch;
        logic        upd_result;
        logic        redirect;
        logic [31:0] redirect_pc;
    } exp_t;

    exp_t        sb[$];
    pred_entry_t model_q[$];
    int          m_branch = 0;
    int          m_misp   = 0;
    logic        m_err    = 1'b0;
    int          checks   = 0;
    int          failures = 0;

    task automatic set_idle();
        bus.push_valid     = 1'b0;
        bus.push_pc        = '0;
        bus.push_target    = '0;
        bus.push_taken     = 1'b0;
        bus.push_is_branch = 1'b0;
        bus.resolve_valid  = 1'b0;
        bus.resolve_taken  = 1'b0;
    endtask

    // Drives one cycle starting just after a rising edge, updates the
    // reference model, queues the expected registered outputs and compares
    // them one edge later.
    task automatic drive_cycle(input logic pv, input logic [31:0] pc,
                               input logic [31:0] tgt, input logic tk,
                               input logic isb, input logic rv, input logic rtk);
        exp_t        e;
        pred_entry_t h;
        pred_entry_t n;
        logic        act;
        logic        misp;
        logic        ready;
        bus.push_valid     = pv;
        bus.push_pc        = pc;
        bus.push_target    = tgt;
        bus.push_taken     = tk;
        bus.push_is_branch = isb;
        bus.resolve_valid  = rv;
        bus.resolve_taken  = rtk;

        ready         = (model_q.size() < DEPTH);
        misp          = 1'b0;
        e.upd_branch  = 1'b0;
        e.upd_result  = 1'b0;
        e.redirect    = 1'b0;
        e.redirect_pc = 32'h0;
        if (rv && model_q.size() > 0) begin
            h    = model_q.pop_front();
            act  = h.is_branch ? rtk : 1'b1;
            misp = (act != h.taken);
            e.upd_branch  = h.is_branch;
            e.upd_result  = act;
            e.redirect    = misp;
            e.redirect_pc = act ? h.target : h.pc + 32'd4;
            if (h.is_branch) m_branch++;
            if (misp) begin
                m_misp++;
                model_q.delete();
            end
        end else if (rv) begin
            m_err = 1'b1;
        end
        if (pv && ready && !misp) begin
            n.pc        = pc;
            n.target    = tgt;
            n.taken     = tk;
            n.is_branch = isb;
            model_q.push_back(n);
        end
        sb.push_back(e);

        @(posedge clk);
        #1;
        set_idle();
        e = sb.pop_front();
        checks++;
        if (bus.upd_branch !== e.upd_branch) begin
            failures++;
            $display("FAIL sb_upd_branch t=%0t got=%b want=%b", $time, bus.upd_branch, e.upd_branch);
        end
        checks++;
        if (bus.upd_result !== e.upd_result) begin
            failures++;
            $display("FAIL sb_upd_result t=%0t got=%b want=%b", $time, bus.upd_result, e.upd_result);
        end
        checks++;
        if (bus.redirect !== e.redirect || bus.flush !== e.redirect) begin
            failures++;
            $display("FAIL sb_redirect t=%0t got=%b/%b want=%b", $time, bus.redirect, bus.flush, e.redirect);
        end
        if (e.redirect) begin
            checks++;
            if (bus.redirect_pc !== e.redirect_pc) begin
                failures++;
                $display("FAIL sb_redirect_pc t=%0t got=%h want=%h", $time, bus.redirect_pc, e.redirect_pc);
            end
        end
        checks++;
        if (count !== CW'(model_q.size())) begin
            failures++;
            $display("FAIL sb_count t=%0t got=%0d want=%0d", $time, count, model_q.size());
        end
        checks++;
        if (err_underflow !== m_err) begin
            failures++;
            $display("FAIL sb_err t=%0t got=%b want=%b", $time, err_underflow, m_err);
        end
        checks++;
        if (branch_count !== CNT_W'(m_branch) || mispredict_count !== CNT_W'(m_misp)) begin
            failures++;
            $display("FAIL sb_counters t=%0t got=%0d/%0d want=%0d/%0d", $time,
                     branch_count, mispredict_count, m_branch, m_misp);
        end
    endtask

    task automatic idle_cycle();
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        #13;
        checks++;
        if (count !== '0 || bus.push_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_fifo count=%0d ready=%b want 0/1", count, bus.push_ready);
        end
        checks++;
        if (bus.redirect !== 1'b0 || bus.flush !== 1'b0 || bus.redirect_pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_redirect got=%b/%b/%h want 0/0/0", bus.redirect, bus.flush, bus.redirect_pc);
        end
        checks++;
        if (bus.upd_branch !== 1'b0 || bus.upd_result !== 1'b0 || err_underflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_misc upd=%b/%b err=%b want 0", bus.upd_branch, bus.upd_result, err_underflow);
        end
        checks++;
        if (branch_count !== '0 || mispredict_count !== '0) begin
            failures++;
            $display("FAIL reset_counters got=%0d/%0d want 0/0", branch_count, mispredict_count);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_correct_predict();
        drive_cycle(1'b1, 32'h100, 32'h140, 1'b1, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (bus.upd_branch !== 1'b1 || bus.upd_result !== 1'b1 || bus.redirect !== 1'b0 || count !== '0) begin
            failures++;
            $display("FAIL correct_predict upd=%b/%b redir=%b count=%0d want 1/1/0/0",
                     bus.upd_branch, bus.upd_result, bus.redirect, count);
        end
        idle_cycle();
        checks++;
        if (bus.upd_branch !== 1'b0) begin
            failures++;
            $display("FAIL pulse_deassert upd_branch=%b want 0", bus.upd_branch);
        end
    endtask

    task automatic test_mispredict_taken();
        drive_cycle(1'b1, 32'h200, 32'h180, 1'b0, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h180 || mispredict_count !== 32'd1) begin
            failures++;
            $display("FAIL mispredict_taken redir=%b pc=%h misp=%0d want 1/180/1",
                     bus.redirect, bus.redirect_pc, mispredict_count);
        end
        idle_cycle();
    endtask

    task automatic test_mispredict_not_taken();
        drive_cycle(1'b1, 32'h300, 32'h3C0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.redirect_pc !== 32'h304) begin
            failures++;
            $display("FAIL mispredict_not_taken pc=%h want 304", bus.redirect_pc);
        end
        idle_cycle();
    endtask

    task automatic test_full_and_flush();
        for (int i = 0; i < DEPTH; i++) begin
            drive_cycle(1'b1, 32'h1000 + 32'(i) * 32'h10, 32'h2000, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        checks++;
        if (bus.push_ready !== 1'b0 || count !== CW'(DEPTH)) begin
            failures++;
            $display("FAIL full_ready ready=%b count=%0d want 0/%0d", bus.push_ready, count, DEPTH);
        end
        drive_cycle(1'b1, 32'h5000, 32'h6000, 1'b1, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'h5000, 32'h6000, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (count !== '0 || bus.redirect_pc !== 32'h1004) begin
            failures++;
            $display("FAIL full_flush count=%0d pc=%h want 0/1004", count, bus.redirect_pc);
        end
        drive_cycle(1'b1, 32'h700, 32'h740, 1'b0, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'h800, 32'h840, 1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if (count !== '0) begin
            failures++;
            $display("FAIL flush_drops_push count=%0d want 0", count);
        end
        idle_cycle();
    endtask

    task automatic test_jal();
        int bc_before;
        bc_before = m_branch;
        drive_cycle(1'b1, 32'h900, 32'hA00, 1'b1, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.upd_branch !== 1'b0 || bus.upd_result !== 1'b1 || bus.redirect !== 1'b0 ||
            branch_count !== CNT_W'(bc_before)) begin
            failures++;
            $display("FAIL jal upd=%b/%b redir=%b bc=%0d want 0/1/0/%0d",
                     bus.upd_branch, bus.upd_result, bus.redirect, branch_count, bc_before);
        end
    endtask

    task automatic test_back_to_back();
        drive_cycle(1'b1, 32'hB00, 32'hB40, 1'b0, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'hC00, 32'hC80, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (count !== CW'(1)) begin
            failures++;
            $display("FAIL push_pop_same_cycle count=%0d want 1", count);
        end
        drive_cycle(1'b1, 32'hFFFF_FFFC, 32'h10, 1'b1, 1'b1, 1'b1, 1'b1);
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h0) begin
            failures++;
            $display("FAIL pc_wrap redir=%b pc=%h want 1/0", bus.redirect, bus.redirect_pc);
        end
        idle_cycle();
    endtask

    task automatic test_underflow();
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (err_underflow !== 1'b1 || bus.upd_branch !== 1'b0) begin
            failures++;
            $display("FAIL underflow err=%b upd=%b want 1/0", err_underflow, bus.upd_branch);
        end
        repeat (3) idle_cycle();
        checks++;
        if (err_underflow !== 1'b1) begin
            failures++;
            $display("FAIL underflow_sticky err=%b want 1", err_underflow);
        end
    endtask

    task automatic test_reset_mid();
        drive_cycle(1'b1, 32'h400, 32'h480, 1'b0, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'h500, 32'h540, 1'b0, 1'b1, 1'b1, 1'b1);
        checks++;
        if (bus.redirect !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_redirect got=%b want 1", bus.redirect);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.redirect !== 1'b0 || bus.flush !== 1'b0 || bus.redirect_pc !== 32'h0 ||
            bus.upd_branch !== 1'b0 || bus.upd_result !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_pulse redir=%b flush=%b pc=%h upd=%b/%b want 0",
                     bus.redirect, bus.flush, bus.redirect_pc, bus.upd_branch, bus.upd_result);
        end
        checks++;
        if (count !== '0 || err_underflow !== 1'b0 || branch_count !== '0 ||
            mispredict_count !== '0 || bus.push_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_state count=%0d err=%b bc=%0d mc=%0d ready=%b want 0/0/0/0/1",
                     count, err_underflow, branch_count, mispredict_count, bus.push_ready);
        end
        model_q.delete();
        sb.delete();
        m_branch = 0;
        m_misp   = 0;
        m_err    = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        drive_cycle(1'b1, 32'h600, 32'h640, 1'b1, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_correct_predict();
        test_mispredict_taken();
        test_mispredict_not_taken();
        test_full_and_flush();
        test_jal();
        test_back_to_back();
        test_underflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
